aes_sbox_sched: RTL and testbench
=================================

# aes_sbox_sched

Time-multiplexed scheduler that shares a small pool of `aes_sbox` instances between two requesters: the round datapath (SubBytes on a 128-bit state) and the key expansion (SubWord on a 32-bit word). It accepts one job at a time through valid/ready, arbitrates round-robin when both request, and streams the job's bytes through the S-box lanes over several cycles. Results come back as a registered, single-cycle completion pulse. It sits between the AES round controller/key schedule and the S-box ROM logic.

## Interface
- `SBOX_LANES`, default 4: number of `aes_sbox` instances (bytes substituted per cycle). Legal values are 1, 2 and 4; any other value is an elaboration error.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `st_valid` in 1: state job request.
- `st_ready` out 1: state job accepted when `st_valid && st_ready` at a clock edge.
- `st_data` in 128: state; byte i = `st_data[127-8i -: 8]`.
- `kw_valid` in 1: key word job request.
- `kw_ready` out 1: key word job handshake.
- `kw_data` in 32: word; byte i = `kw_data[31-8i -: 8]`.
- `st_done` out 1: one-cycle completion pulse for a state job.
- `st_result` out 128: SubBytes(`st_data`), same byte layout.
- `kw_done` out 1: one-cycle completion pulse for a key word job.
- `kw_result` out 32: SubWord(`kw_data`).
- `busy` out 1: a job is in flight.

## Operation
- FSM states: IDLE, RUN_ST, RUN_KW.
- IDLE: `st_ready` and `kw_ready` are combinational and high only in IDLE, gated by the grant.
  - One requester valid: that requester is granted.
  - Both valid: grant the requester not served last (`last_kw` flag). After reset the key word wins.
  - Only the granted ready is high. The other waits and must hold valid/data stable.
- Handshake: the input word is captured into an operand register, lane counter is cleared to 0, the FSM moves to RUN_ST or RUN_KW, and `last_kw` is updated.
- RUN: each cycle, lanes 0..SBOX_LANES-1 substitute operand bytes `cnt*SBOX_LANES + lane`. Results are written into the result register at the same byte positions. `cnt` increments.
  - Beats per job: N = 16/SBOX_LANES (state) or 4/SBOX_LANES (word). SBOX_LANES=4 makes a word job a single beat.
- Final beat (`cnt == N-1`): the last bytes are written, the matching done is registered high for one cycle, and the FSM returns to IDLE.
- `st_result` and `kw_result` are separate registers. Each holds its value until the next completion of the same job type. Partial writes during a job are visible on the result bus; consumers sample only on done.
- The S-box inputs are driven with 0x00 when idle. Their outputs are ignored.
- `busy` = (state != IDLE).
- Reset (asynchronous, including mid-job): the FSM goes to IDLE, the job is discarded, `cnt`=0, `last_kw`=0, and no done is produced.

## Timing
- Reset values:
  - `st_done`=0, `kw_done`=0, `busy`=0.
  - `st_result`=0, `kw_result`=0.
  - `st_ready` and `kw_ready` follow IDLE arbitration (high on a valid request).
- Latency: handshake at edge E0 → done high during the cycle after edge E0+N.
  - SBOX_LANES=4: state N=4, word N=1.
  - SBOX_LANES=1: state N=16, word N=4.
- Done pulse and `busy` falling occur at the same edge. The ready for the next job is high in that same cycle, so back-to-back jobs are spaced N+1 cycles apart.
- Done outputs have no backpressure. Consumers must accept them.
- Valid asserted while busy is held. The handshake occurs at the first IDLE edge.

## Configuration
- `AES_SBOX_SCHED_KW_EN`:
  - Defined: the key word port, arbitration and `kw_result` register are present, as described above.
  - Undefined: the ports remain but are inert. `kw_ready`, `kw_done` and `kw_result` are tied to 0. `kw_valid` is ignored. `st_ready` = IDLE, with no arbitration logic or `last_kw`.

## Test plan
- State job, SBOX_LANES=4: `st_data`=0x000102030405060708090a0b0c0d0e0f → `st_result`=0x637c777bf26b6fc53001672bfed7ab76, `st_done` 4 cycles after handshake for exactly 1 cycle.
- Word job: `kw_data`=0x09cf4f3c → `kw_result`=0x018a84eb, `kw_done` 1 cycle after handshake (LANES=4) and 4 cycles after (LANES=1).
- Simultaneous requests after reset, `st_data`=all 0x53, `kw_data`=0xffffffff:
  - Key word is served first (`kw_result`=0x16161616).
  - Then state (`st_result`=all 0xed).
  - A second simultaneous pair is served state first.
- Reset mid-job: assert `rst_n`=0 at beat 2 of a state job → outputs 0, no `st_done`, `st_ready` high after release. A new job then completes correctly.
- Back-to-back: `st_valid` held for 3 jobs → handshakes spaced N+1 cycles apart, each `st_result` matches the per-job FIPS-197 S-box table.
- Macro undefined: `kw_valid`=1 held → `kw_ready`, `kw_done` and `kw_result` stay 0; state jobs are unaffected.

Source files
------------

// File: rtl/aes_sbox_sched.sv
// aes_sbox_sched: shares SBOX_LANES S-box instances between SubBytes (128-bit state) and SubWord (32-bit key word) jobs.
// Latency: handshake edge E0 -> done pulse in the cycle after edge E0+N (N = 16/SBOX_LANES state, 4/SBOX_LANES word).
// Backpressure: one job at a time via valid/ready (ready only while idle); done pulses have no backpressure.
// Optional macro AES_SBOX_SCHED_KW_EN enables the key word requester; when undefined the kw_* ports are inert.

// aes_sbox: combinational FIPS-197 S-box, computed as GF(2^8) inverse followed by the affine transform.
// Latency: zero cycles (pure combinational).
// Backpressure: none.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] xx;
        p  = 8'h00;
        xx = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ xx;
            xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; 0 maps to 0 naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign s = affine(gf_inv(a));

endmodule

// aes_sbox_sched: round-robin scheduler streaming state/word bytes through a shared S-box pool.
// Latency: N+1 cycles from handshake to done visible (N beats plus the registered done).
// Backpressure: requesters hold valid/data until ready; ready is high only in IDLE for the granted side.
module aes_sbox_sched #(
    parameter int SBOX_LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [127:0] st_data,
    input  logic         kw_valid,
    output logic         kw_ready,
    input  logic [31:0]  kw_data,
    output logic         st_done,
    output logic [127:0] st_result,
    output logic         kw_done,
    output logic [31:0]  kw_result,
    output logic         busy
);

    localparam int ST_BEATS = 16 / SBOX_LANES;
    localparam int KW_BEATS = 4 / SBOX_LANES;

    // Byte 0 lives in the most significant byte, so byte i is element [15-i] / [3-i].
    typedef logic [15:0][7:0] aes_state_t;
    typedef logic [3:0][7:0]  aes_word_t;
    typedef enum logic [1:0] {IDLE, RUN_ST, RUN_KW} state_t;

    generate
        if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_bad_lanes
            $error("aes_sbox_sched: SBOX_LANES must be 1, 2 or 4");
        end
    endgenerate

    state_t     state;
    logic [3:0] cnt;
    aes_state_t op;
    aes_state_t st_res;
    logic       st_done_r;
    logic [7:0] sb_in    [SBOX_LANES];
    logic [7:0] sb_out   [SBOX_LANES];
    logic [3:0] byte_idx [SBOX_LANES];

    // Lane l handles byte cnt*SBOX_LANES + l; lanes see 0x00 while idle to keep them quiet.
    always_comb begin
        for (int l = 0; l < SBOX_LANES; l++) begin
            byte_idx[l] = cnt * 4'(SBOX_LANES) + 4'(l);
            sb_in[l]    = (state == IDLE) ? 8'h00 : op[4'd15 - byte_idx[l]];
        end
    end

    for (genvar g = 0; g < SBOX_LANES; g++) begin : g_lane
        aes_sbox u_sbox (
            .a (sb_in[g]),
            .s (sb_out[g])
        );
    end

`ifdef AES_SBOX_SCHED_KW_EN
    aes_word_t kw_res;
    logic      kw_done_r;
    logic      last_kw;
    logic      grant_kw;

    // Round-robin grant: the key word wins a tie unless it was the last one served.
    always_comb begin
        grant_kw = kw_valid && (!st_valid || !last_kw);
        st_ready = (state == IDLE) && st_valid && !grant_kw;
        kw_ready = (state == IDLE) && grant_kw;
    end

    assign kw_done   = kw_done_r;
    assign kw_result = kw_res;
`else
    logic unused_kw;

    assign unused_kw = ^{kw_valid, kw_data};
    assign st_ready  = (state == IDLE);
    assign kw_ready  = 1'b0;
    assign kw_done   = 1'b0;
    assign kw_result = 32'h0;
`endif

    // Job FSM: capture operand on handshake, write lane results per beat, pulse done on the final beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            op        <= '0;
            st_res    <= '0;
            st_done_r <= 1'b0;
`ifdef AES_SBOX_SCHED_KW_EN
            kw_res    <= '0;
            kw_done_r <= 1'b0;
            last_kw   <= 1'b0;
`endif
        end else begin
            st_done_r <= 1'b0;
`ifdef AES_SBOX_SCHED_KW_EN
            kw_done_r <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (st_valid && st_ready) begin
                        op    <= st_data;
                        cnt   <= 4'd0;
                        state <= RUN_ST;
`ifdef AES_SBOX_SCHED_KW_EN
                        last_kw <= 1'b0;
`endif
                    end
`ifdef AES_SBOX_SCHED_KW_EN
                    else if (kw_valid && kw_ready) begin
                        op      <= {kw_data, 96'h0};
                        cnt     <= 4'd0;
                        state   <= RUN_KW;
                        last_kw <= 1'b1;
                    end
`endif
                end
                RUN_ST: begin
                    for (int l = 0; l < SBOX_LANES; l++) begin
                        st_res[4'd15 - byte_idx[l]] <= sb_out[l];
                    end
                    if (cnt == 4'(ST_BEATS - 1)) begin
                        st_done_r <= 1'b1;
                        cnt       <= 4'd0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RUN_KW: begin
`ifdef AES_SBOX_SCHED_KW_EN
                    for (int l = 0; l < SBOX_LANES; l++) begin
                        kw_res[2'd3 - byte_idx[l][1:0]] <= sb_out[l];
                    end
                    if (cnt == 4'(KW_BEATS - 1)) begin
                        kw_done_r <= 1'b1;
                        cnt       <= 4'd0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign st_done   = st_done_r;
    assign st_result = st_res;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_aes_sbox_sched.sv
// tb_aes_sbox_sched: directed and random jobs checked against a table-driven transaction model.
// Latency: n/a (testbench).
// Backpressure: drivers hold valid/data until the handshake, as a real requester must.
module tb_aes_sbox_sched;

    localparam int LANES = 4;
    localparam int ST_N  = 16 / LANES;
    localparam int KW_N  = 4 / LANES;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         st_valid = 1'b0;
    logic [127:0] st_data  = '0;
    logic         kw_valid = 1'b0;
    logic [31:0]  kw_data  = '0;
    logic         st_ready, kw_ready, st_done, kw_done, busy;
    logic [127:0] st_result;
    logic [31:0]  kw_result;

    aes_sbox_sched #(.SBOX_LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_data   (st_data),
        .kw_valid  (kw_valid),
        .kw_ready  (kw_ready),
        .kw_data   (kw_data),
        .st_done   (st_done),
        .st_result (st_result),
        .kw_done   (kw_done),
        .kw_result (kw_result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    // FIPS-197 S-box, one row per high nibble.
    logic [127:0] sbox_rows [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [127:0] row;
        int col;
        row = sbox_rows[x[7:4]];
        col = int'(x[3:0]);
        return row[127 - 8*col -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = sbox(d[127 - 8*i -: 8]);
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[31 - 8*i -: 8] = sbox(d[31 - 8*i -: 8]);
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: cycles left in the current job, which requester it serves, held results.
    int           m_rem = 0;
    bit           m_job_kw = 1'b0;
    logic [127:0] m_st_op = '0;
    logic [31:0]  m_kw_op = '0;
    bit           m_last_kw = 1'b0;
    bit           m_st_done = 1'b0;
    bit           m_kw_done = 1'b0;
    logic [127:0] m_st_res = '0;
    logic [31:0]  m_kw_res = '0;

    // Compare outputs against the model mid-cycle, then advance the model across the next edge.
    always @(negedge clk) begin : scoreboard
        bit exp_st_rdy;
        bit exp_kw_rdy;
        bit gkw;
        if (!rst_n) begin
            m_rem = 0; m_last_kw = 1'b0; m_st_done = 1'b0; m_kw_done = 1'b0;
            m_st_res = '0; m_kw_res = '0;
        end
        exp_st_rdy = 1'b0;
        exp_kw_rdy = 1'b0;
        gkw = 1'b0;
        if (m_rem == 0) begin
`ifdef AES_SBOX_SCHED_KW_EN
            gkw = kw_valid && (!st_valid || !m_last_kw);
            exp_kw_rdy = gkw;
            exp_st_rdy = st_valid && !gkw;
`else
            exp_st_rdy = 1'b1;
`endif
        end
        check("st_ready", st_ready, exp_st_rdy);
        check("kw_ready", kw_ready, exp_kw_rdy);
        check("busy", busy, m_rem != 0);
        check("st_done", st_done, m_st_done);
        check("kw_done", kw_done, m_kw_done);
        if (!(m_rem != 0 && !m_job_kw)) check("st_result", st_result, m_st_res);
        if (!(m_rem != 0 && m_job_kw))  check("kw_result", kw_result, m_kw_res);

        m_st_done = 1'b0;
        m_kw_done = 1'b0;
        if (rst_n) begin
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_job_kw) begin m_kw_done = 1'b1; m_kw_res = sub_word(m_kw_op); end
                    else          begin m_st_done = 1'b1; m_st_res = sub_bytes(m_st_op); end
                end
            end else if (exp_st_rdy && st_valid) begin
                m_job_kw = 1'b0; m_st_op = st_data; m_rem = ST_N; m_last_kw = 1'b0;
            end else if (exp_kw_rdy && kw_valid) begin
                m_job_kw = 1'b1; m_kw_op = kw_data; m_rem = KW_N; m_last_kw = 1'b1;
            end
        end
    end

    // One job end to end; wt = mid-cycle samples until ready, lat = edges from handshake to done.
    task automatic do_job(input bit is_kw, input logic [127:0] d, output int wt, output int lat);
        bit got;
        got = 1'b0; wt = 0; lat = 0;
        if (is_kw) begin kw_valid = 1'b1; kw_data = d[31:0]; end
        else       begin st_valid = 1'b1; st_data = d; end
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            wt++;
            if (is_kw ? kw_ready : st_ready) begin got = 1'b1; break; end
        end
        check(is_kw ? "kw_handshake_seen" : "st_handshake_seen", got, 1);
        @(posedge clk); #1;
        if (is_kw) kw_valid = 1'b0; else st_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            lat++;
            if (is_kw ? kw_done : st_done) begin got = 1'b1; break; end
        end
        check(is_kw ? "kw_done_seen" : "st_done_seen", got, 1);
        lat = lat - 1;
        @(negedge clk);
        check(is_kw ? "kw_done_width" : "st_done_width", is_kw ? kw_done : st_done, 0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

`ifdef AES_SBOX_SCHED_KW_EN
    // Both requesters at once with the 0x53 / 0xff operands; first = 1 key word first, 2 state first.
    task automatic run_pair(output int first);
        int nd;
        bit as, ak;
        nd = 0; first = 0;
        st_valid = 1'b1; st_data = {16{8'h53}};
        kw_valid = 1'b1; kw_data = 32'hffffffff;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            as = st_valid && st_ready;
            ak = kw_valid && kw_ready;
            if (kw_done) begin nd++; if (first == 0) first = 1; check("pair_kw_result", kw_result, 32'h16161616); end
            if (st_done) begin nd++; if (first == 0) first = 2; check("pair_st_result", st_result, {16{8'hed}}); end
            @(posedge clk); #1;
            if (as) st_valid = 1'b0;
            if (ak) kw_valid = 1'b0;
            if (nd == 2) break;
        end
        check("pair_both_done", nd, 2);
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int wt, lat, first, nhs;
        int hs [3];
        bit acc_s, acc_k;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_st_done", st_done, 0);
        check("rst_st_result", st_result, 0);
        check("rst_kw_result", kw_result, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // FIPS-197 counting-pattern state.
        do_job(1'b0, 128'h000102030405060708090a0b0c0d0e0f, wt, lat);
        check("st_vector_result", st_result, 128'h637c777bf26b6fc53001672bfed7ab76);
        check("st_latency", lat, ST_N);

`ifdef AES_SBOX_SCHED_KW_EN
        do_job(1'b1, 128'h09cf4f3c, wt, lat);
        check("kw_vector_result", kw_result, 32'h018a84eb);
        check("kw_latency", lat, KW_N);

        // After reset the key word wins a tie; state follows.
        pulse_reset();
        run_pair(first);
        check("pair1_kw_first", first, 1);
        // A lone key word job leaves the key word as last served, so the next tie goes to state.
        do_job(1'b1, 128'h00112233, wt, lat);
        check("lone_kw_result", kw_result, 32'h638293c3);
        run_pair(first);
        check("pair2_st_first", first, 2);
`else
        // Key word requester is inert: held valid never sees ready, state jobs unaffected.
        kw_valid = 1'b1; kw_data = 32'h09cf4f3c;
        do_job(1'b0, {16{8'h53}}, wt, lat);
        check("inert_st_result", st_result, {16{8'hed}});
        check("inert_kw_ready", kw_ready, 0);
        check("inert_kw_result", kw_result, 0);
        kw_valid = 1'b0;
`endif

        // Reset at beat 2 of a state job discards it.
        st_valid = 1'b1; st_data = 128'h0f0e0d0c0b0a09080706050403020100;
        for (int k = 0; k < 50; k++) begin @(negedge clk); if (st_ready) break; end
        @(posedge clk); #1 st_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_st_done", st_done, 0);
        check("midrst_busy", busy, 0);
        check("midrst_st_result", st_result, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        do_job(1'b0, {16{8'h53}}, wt, lat);
        check("midrst_ready_after_release", wt, 1);
        check("midrst_new_result", st_result, {16{8'hed}});

        // Back-to-back: valid held across three state jobs.
        nhs = 0;
        st_valid = 1'b1; st_data = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < 300 && nhs < 3; k++) begin
            @(negedge clk);
            acc_s = st_valid && st_ready;
            if (acc_s) begin hs[nhs] = cyc; nhs++; end
            @(posedge clk); #1;
            if (acc_s) begin
                st_data = {$urandom, $urandom, $urandom, $urandom};
                if (nhs == 3) st_valid = 1'b0;
            end
        end
        check("b2b_handshakes", nhs, 3);
        if (nhs == 3) begin
            check("b2b_spacing_1", hs[1] - hs[0], ST_N + 1);
            check("b2b_spacing_2", hs[2] - hs[1], ST_N + 1);
        end
        repeat (ST_N + 2) @(posedge clk);
        #1;

        // Random traffic with occasional asynchronous resets; requests held until accepted.
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            acc_s = rst_n && st_valid && st_ready;
            acc_k = rst_n && kw_valid && kw_ready;
            @(posedge clk); #1;
            rst_n = ($urandom_range(0, 199) != 0);
            if (!st_valid || acc_s) begin
                st_valid = ($urandom_range(0, 2) != 0);
                st_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!kw_valid || acc_k) begin
                kw_valid = ($urandom_range(0, 2) != 0);
                kw_data  = $urandom;
            end
        end
        rst_n = 1'b1;
        st_valid = 1'b0;
        kw_valid = 1'b0;
        repeat (ST_N + 4) @(posedge clk);
        @(negedge clk);
        check("final_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
